// File: rtl/rbot_pkg.sv
// rbot_pkg - shared types and constants for the cube-robot motion path.
//
// Contents:
//   NUM_FACES              number of cube faces / stepper drivers
//   DEFAULT_QUARTER_STEPS  default motor steps per 90 degree turn
//   face_t                 face code enum (U=0, D=1, F=2, B=3, L=4, R=5)
//   move_t                 one queued move {face, dir, half}
//   face_onehot()          face code to one-hot driver select
package rbot_pkg;

  localparam int NUM_FACES             = 6;
  localparam int DEFAULT_QUARTER_STEPS = 50;

  typedef enum logic [2:0] {
    FACE_U = 3'd0,
    FACE_D = 3'd1,
    FACE_F = 3'd2,
    FACE_B = 3'd3,
    FACE_L = 3'd4,
    FACE_R = 3'd5
  } face_t;

  typedef struct packed {
    face_t face;
    logic  dir;
    logic  half;
  } move_t;

  function automatic logic [NUM_FACES-1:0] face_onehot(input face_t f);
    logic [NUM_FACES-1:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo - synchronous first-word fall-through FIFO of move_t entries.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   push           write push_data (ignored while full)
//   push_data      move to enqueue
//   pop            discard the head entry (ignored while empty)
//   head           oldest entry, valid whenever empty is low
//   full, empty    occupancy flags
//   count          current occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap naturally.
module move_fifo
  import rbot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  move_t                    push_data,
  input  logic                     pop,
  output move_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  move_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_V);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer - queues cube moves and drives the six per-face steppers
// one move at a time.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   move_valid       command present
//   move_face        face code 0..5 = U,D,F,B,L,R (6,7 illegal)
//   move_dir         0 = clockwise, 1 = counter-clockwise
//   move_half        1 = 180 degree turn
//   move_ready       queue not full; command taken on move_valid & move_ready
//   driver_done      done level from each stepper driver, bit = face code
//   driver_start     one-cycle start pulse to the selected driver
//   driver_dir       direction level per face, held until that face restarts
//   steps            step count for the move being launched, held afterwards
//   busy             queue non-empty or a move/settle gap still in progress
//   queue_count      current queue occupancy
//   moves_done       completed move counter (only with MOVE_SEQ_COUNT_EN)
//   illegal_move     sticky flag, set when an illegal face code is accepted
//
// Build option: define MOVE_SEQ_COUNT_EN to add the 16-bit moves_done port.
module move_sequencer
  import rbot_pkg::*;
#(
  parameter int QUARTER_STEPS = DEFAULT_QUARTER_STEPS,
  parameter int FIFO_DEPTH    = 8,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          move_valid,
  input  logic [2:0]                    move_face,
  input  logic                          move_dir,
  input  logic                          move_half,
  output logic                          move_ready,
  input  logic [NUM_FACES-1:0]          driver_done,
  output logic [NUM_FACES-1:0]          driver_start,
  output logic [NUM_FACES-1:0]          driver_dir,
  output logic [7:0]                    steps,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count,
`ifdef MOVE_SEQ_COUNT_EN
  output logic [15:0]                   moves_done,
`endif
  output logic                          illegal_move
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  // The gap counter only ever holds GAP_CYCLES-1 down to 0.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [7:0] QUARTER8 = 8'(QUARTER_STEPS);
  localparam logic [7:0] HALF8    = 8'(2 * QUARTER_STEPS);

  logic [2:0]     state;
  face_t          cur_face;
  logic [GW-1:0]  gap_count;

  move_t          head;
  move_t          push_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           face_legal;
  logic           push;
  logic           pop;
  logic           move_finished;

  assign move_ready     = ~fifo_full;
  assign accept         = move_valid & move_ready;
  assign face_legal     = (move_face < 3'(NUM_FACES));
  assign push           = accept & face_legal;
  assign push_data.face = face_t'(move_face);
  assign push_data.dir  = move_dir;
  assign push_data.half = move_half;
  assign pop            = (state == S_IDLE) & ~fifo_empty;
  assign busy           = ~fifo_empty | (state != S_IDLE);
  assign move_finished  = (state == S_RUN) & driver_done[cur_face];

  move_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  // Move FSM. The start pulse is registered when the head is popped so it
  // is high for exactly the LAUNCH cycle. ARM waits out the stale done the
  // driver still shows from its previous move before RUN looks for the
  // new rising done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cur_face     <= FACE_U;
      gap_count    <= '0;
      driver_start <= '0;
      driver_dir   <= '0;
      steps        <= '0;
    end else begin
      driver_start <= '0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_face              <= head.face;
            steps                 <= head.half ? HALF8 : QUARTER8;
            driver_dir[head.face] <= head.dir;
            driver_start          <= face_onehot(head.face);
            state                 <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state <= S_ARM;
        end
        S_ARM: begin
          if (!driver_done[cur_face]) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (driver_done[cur_face]) begin
            gap_count <= GW'(GAP_CYCLES - 1);
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_count == '0) begin
            state <= S_IDLE;
          end else begin
            gap_count <= gap_count - GW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Illegal face codes are swallowed at the input; the flag stays set
  // until reset so the host can notice it later.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_move <= 1'b0;
    end else if (accept && !face_legal) begin
      illegal_move <= 1'b1;
    end
  end

`ifdef MOVE_SEQ_COUNT_EN
  // Counts RUN->GAP transitions; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      moves_done <= '0;
    end else if (move_finished) begin
      moves_done <= moves_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer - scoreboard bench for move_sequencer.
// Accepted legal moves push an expected start event; a monitor pops one
// per observed driver_start pulse. A behavioural stepper model answers
// each start with a one-cycle stale done, a low period and a rising done.
module tb_move_sequencer;

  localparam int GAP     = 20;
  localparam int RUN_LEN = 100;

  typedef struct packed {
    logic [5:0] onehot;
    logic [7:0] steps;
    logic       dir;
    logic [2:0] face;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        move_valid;
  logic [2:0]  move_face;
  logic        move_dir;
  logic        move_half;
  logic        move_ready;
  logic [5:0]  driver_done;
  logic [5:0]  driver_start;
  logic [5:0]  driver_dir;
  logic [7:0]  steps;
  logic        busy;
  logic [3:0]  queue_count;
  logic        illegal_move;
`ifdef MOVE_SEQ_COUNT_EN
  logic [15:0] moves_done;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_count = 0;
  int   last_start_cyc = 0;
  int   rise_cyc = 0;
  logic stall = 1'b0;
  logic [5:0] model_dir = '0;
  exp_t sb[$];

  move_sequencer #(
    .QUARTER_STEPS (50),
    .FIFO_DEPTH    (8),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .move_valid   (move_valid),
    .move_face    (move_face),
    .move_dir     (move_dir),
    .move_half    (move_half),
    .move_ready   (move_ready),
    .driver_done  (driver_done),
    .driver_start (driver_start),
    .driver_dir   (driver_dir),
    .steps        (steps),
    .busy         (busy),
    .queue_count  (queue_count),
`ifdef MOVE_SEQ_COUNT_EN
    .moves_done   (moves_done),
`endif
    .illegal_move (illegal_move)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one command from a negedge, waits (bounded) for move_ready and
  // returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [2:0] face, input logic dir,
                               input logic half, input int budget);
    int   waited;
    exp_t e;
    waited     = 0;
    move_valid = 1'b1;
    move_face  = face;
    move_dir   = dir;
    move_half  = half;
    while (!move_ready && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    if (!move_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: move_ready=%0b after %0d cycles, required 1", move_ready, waited);
      move_valid = 1'b0;
      return;
    end
    @(posedge clock);
    if (face < 3'd6) begin
      e.onehot = 6'b000001 << face;
      e.steps  = half ? 8'd100 : 8'd50;
      e.dir    = dir;
      e.face   = face;
      sb.push_back(e);
    end
    @(negedge clock);
    move_valid = 1'b0;
  endtask

  task automatic waitStarts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (start_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (start_count < target) begin
      errors++;
      $display("[TB] FAIL %s: starts=%0d, required %0d", name, start_count, target);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: busy=%0b pending=%0d, required idle", name, busy, sb.size());
    end
  endtask

  // Stepper model: done stays high (stale) through the ARM cycle, drops,
  // and rises again RUN_LEN cycles later unless the bench is stalling it.
  initial begin : driver_model
    int f;
    driver_done = 6'h3f;
    forever begin
      @(negedge clock);
      if (driver_start != 6'h00) begin
        f = 0;
        for (int i = 0; i < 6; i++) begin
          if (driver_start[i]) f = i;
        end
        repeat (2) @(negedge clock);
        driver_done[f] = 1'b0;
        repeat (RUN_LEN) @(negedge clock);
        while (stall) @(negedge clock);
        driver_done[f] = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  // Monitor: every start pulse must match the oldest outstanding move.
  initial begin : monitor
    exp_t e;
    logic pending_width;
    pending_width = 1'b0;
    forever begin
      @(negedge clock);
      if (pending_width) begin
        pending_width = 1'b0;
        checkOutput("start_width", 32'(driver_start), 32'h0);
      end
      if (reset) begin
        sb.delete();
        model_dir = '0;
      end else if (driver_start != 6'h00) begin
        start_count++;
        last_start_cyc = cyc;
        pending_width  = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_start: driver_start=0x%0h, required no start", driver_start);
        end else begin
          e = sb.pop_front();
          checkOutput("start_onehot", 32'(driver_start), 32'(e.onehot));
          checkOutput("steps", 32'(steps), 32'(e.steps));
          model_dir[e.face] = e.dir;
          checkOutput("driver_dir", 32'(driver_dir), 32'(model_dir));
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    move_valid = 1'b0;
    move_face  = 3'd0;
    move_dir   = 1'b0;
    move_half  = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset values
    checkOutput("rst_move_ready", 32'(move_ready), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_queue_count", 32'(queue_count), 32'h0);
    checkOutput("rst_illegal", 32'(illegal_move), 32'h0);
    checkOutput("rst_driver_start", 32'(driver_start), 32'h0);
    checkOutput("rst_steps", 32'(steps), 32'h0);
    checkOutput("rst_driver_dir", 32'(driver_dir), 32'h0);

    // F cw quarter, then R ccw half queued behind it
    base = start_count;
    applyStimulus(3'd2, 1'b0, 1'b0, 10);
    applyStimulus(3'd5, 1'b1, 1'b1, 10);
    waitStarts(base + 2, RUN_LEN + GAP + 40, "second_start");
    checkOutput("gap_latency", 32'(last_start_cyc - rise_cyc), 32'(GAP + 2));
    repeat (5) @(negedge clock);
    checkOutput("steps_held", 32'(steps), 32'd100);
    checkOutput("dir_held", 32'(driver_dir), 32'h20);
    waitIdle(RUN_LEN + GAP + 40, "idle_after_two");

    // Illegal face
    base = start_count;
    applyStimulus(3'd7, 1'b0, 1'b0, 10);
    checkOutput("illegal_set", 32'(illegal_move), 32'h1);
    checkOutput("illegal_qcount", 32'(queue_count), 32'h0);
    checkOutput("illegal_busy", 32'(busy), 32'h0);
    repeat (10) @(negedge clock);
    checkOutput("illegal_no_start", 32'(start_count), 32'(base));

    // Stalled driver: fill the queue behind a move stuck in RUN
    stall = 1'b1;
    base  = start_count;
    applyStimulus(3'd0, 1'b1, 1'b0, 10);
    waitStarts(base + 1, 20, "stall_first_start");
    repeat (4) @(negedge clock);
    applyStimulus(3'd1, 1'b0, 1'b0, 5);
    applyStimulus(3'd2, 1'b1, 1'b1, 5);
    applyStimulus(3'd3, 1'b0, 1'b1, 5);
    applyStimulus(3'd4, 1'b1, 1'b0, 5);
    applyStimulus(3'd5, 1'b0, 1'b0, 5);
    applyStimulus(3'd0, 1'b0, 1'b1, 5);
    applyStimulus(3'd1, 1'b1, 1'b1, 5);
    applyStimulus(3'd2, 1'b0, 1'b0, 5);
    checkOutput("full_qcount", 32'(queue_count), 32'd8);
    checkOutput("full_ready", 32'(move_ready), 32'h0);
    move_valid = 1'b1;
    move_face  = 3'd3;
    move_dir   = 1'b1;
    move_half  = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("held_qcount", 32'(queue_count), 32'd8);
    checkOutput("held_ready", 32'(move_ready), 32'h0);
    stall = 1'b0;
    applyStimulus(3'd3, 1'b1, 1'b0, RUN_LEN + GAP + 40);
    stall = 1'b1;
    checkOutput("refill_qcount", 32'(queue_count), 32'd8);
    checkOutput("illegal_sticky", 32'(illegal_move), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("illegal_cleared", 32'(illegal_move), 32'h0);
    base  = start_count;
    stall = 1'b0;
    repeat (RUN_LEN + GAP + 20) @(negedge clock);
    checkOutput("no_start_after_reset1", 32'(start_count), 32'(base));

    // Reset during RUN with three queued moves
    stall = 1'b1;
    base  = start_count;
    applyStimulus(3'd4, 1'b1, 1'b0, 10);
    waitStarts(base + 1, 20, "run_reset_start");
    repeat (4) @(negedge clock);
    applyStimulus(3'd0, 1'b1, 1'b1, 5);
    applyStimulus(3'd1, 1'b0, 1'b0, 5);
    applyStimulus(3'd5, 1'b1, 1'b0, 5);
    checkOutput("three_queued", 32'(queue_count), 32'd3);
    checkOutput("busy_in_run", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_reset_qcount", 32'(queue_count), 32'h0);
    checkOutput("mid_reset_busy", 32'(busy), 32'h0);
    checkOutput("mid_reset_ready", 32'(move_ready), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mid_reset_dir", 32'(driver_dir), 32'h0);
    checkOutput("mid_reset_steps", 32'(steps), 32'h0);
    base  = start_count;
    stall = 1'b0;
    repeat (RUN_LEN + GAP + 20) @(negedge clock);
    checkOutput("no_start_after_reset2", 32'(start_count), 32'(base));

    // Three complete moves from a clean reset
    applyStimulus(3'd3, 1'b0, 1'b1, 10);
    applyStimulus(3'd4, 1'b0, 1'b0, 10);
    applyStimulus(3'd1, 1'b1, 1'b0, 10);
    waitIdle(3 * (RUN_LEN + GAP + 20), "idle_after_three");
    checkOutput("final_dir", 32'(driver_dir), 32'h02);
`ifdef MOVE_SEQ_COUNT_EN
    checkOutput("moves_done", 32'(moves_done), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Upstream of the six per-face stepper drivers.
- Accepts cube move commands (face, direction, quarter/half turn) from the solver/UART front end into a small FIFO.
- Converts each command to a step count and direction, then pulses start on exactly one driver. It waits for that driver's done, inserts a settle gap, and then issues the next move.
- Moves are strictly serialised; only one face turns at a time.

Parameters:
- QUARTER_STEPS, 50, motor steps per 90° turn; legal range 1..127, so a half turn fits in 8 bits.
- FIFO_DEPTH, 8, move queue entries; power of two, 2..32.
- GAP_CYCLES, 1000, clock cycles idle between the rising done of one move and the start of the next; minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move_valid  in  1  command present
- move_face  in  3  face code 0..5 = U,D,F,B,L,R; 6,7 illegal
- move_dir  in  1  0 = clockwise, 1 = counter-clockwise
- move_half  in  1  1 = 180° turn, ignores move_dir for the step count only
- move_ready  out  1  FIFO not full; command accepted when move_valid & move_ready
- driver_done  in  6  done from each stepper driver, bit = face code
- driver_start  out  6  one-cycle start pulse to the selected driver
- driver_dir  out  6  direction level per face; held until that face is next started
- steps  out  8  step count, shared bus to all drivers; valid during the start pulse and held afterwards
- busy  out  1  FIFO non-empty or FSM not IDLE
- queue_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- illegal_move  out  1  sticky; set when an illegal face code is accepted

Behaviour:
- Reset values: driver_start=0, driver_dir=0, steps=0, move_ready=1, busy=0, queue_count=0, illegal_move=0, FIFO empty, FSM=IDLE, gap counter=0.
- Accept rule: an accepted illegal face (6,7) is not enqueued and sets illegal_move. It is cleared only by reset. Legal moves are enqueued.
- FIFO: first-word fall-through.
  - A simultaneous push and pop when full is not possible, because move_ready=0 when full.
  - A simultaneous push and pop at other occupancies keeps queue_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head. Latch face, steps = move_half ? 2*QUARTER_STEPS : QUARTER_STEPS, and driver_dir[face] = move_dir. Go to LAUNCH.
  - LAUNCH: driver_start[face]=1 for exactly this cycle. Go to ARM.
  - ARM: wait for driver_done[face]==0. This covers the driver's stale done from the previous move, which lasts one cycle. Then go to RUN.
  - RUN: wait for driver_done[face]==1. Then load the gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE.
- Latency:
  - Pop to start pulse: 1 cycle. The pop happens in IDLE; the pulse follows in LAUNCH.
  - Done rising to next start: GAP_CYCLES+2 cycles when the queue is non-empty.
- driver_done bits of unselected faces are ignored.
- driver_dir bits of other faces keep their last value.
- Pushes during any state are accepted while not full; they do not disturb the move in flight.
- Reset mid-move:
  - The FSM returns to IDLE and the FIFO empties. No further start is issued.
  - The driver in flight completes on its own; the sequencer does not wait for it.
- Arithmetic: the steps doubling is 8-bit; the parameter range guarantees no overflow.

Optional Feature:
- Macro: MOVE_SEQ_COUNT_EN.
- Defined:
  - Adds output moves_done [15:0], reset to 0.
  - It increments on each RUN→GAP transition and wraps 0xFFFF→0.
- Undefined:
  - The port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rbot_pkg holds:
  - face_t enum (U=0,D=1,F=2,B=3,L=4,R=5)
  - move_t struct {face, dir, half}
  - NUM_FACES=6
  - default QUARTER_STEPS
- Sub-module move_fifo: parameterised sync FIFO of move_t with push/pop/full/empty/count.
- The FSM and gap counter stay in move_sequencer.

Test Plan:
- Reset, then push {F,cw,quarter}:
  - driver_start[2] pulses once, with steps=50 and driver_dir[2]=0.
  - Hold driver_done[2]=1 for 1 cycle then 0; raise it after 100 cycles.
  - Next start ≥ GAP_CYCLES+2 cycles later.
- Push {R,ccw,half}: steps=100, driver_dir[5]=1, only bit 5 of driver_start pulses.
- Push 9 moves back-to-back with done held low (drivers stalled):
  - move_ready drops after the queue holds 8 entries; queue_count=8.
  - The 9th push is held off until a pop.
- Push face=7: not enqueued, illegal_move=1, no start pulse, queue_count unchanged.
- Assert reset during RUN with 3 queued moves:
  - Next cycle FSM=IDLE, queue_count=0, busy=0.
  - No driver_start afterwards, even when driver_done later rises.
- With MOVE_SEQ_COUNT_EN defined, complete 3 moves: moves_done=3. Without the macro, the build elaborates with no moves_done port.
